// File: rtl/play_pause_pkg.sv
// Shared types and constants for the play/pause controller.
package play_pause_pkg;

  typedef enum logic [1:0] {
    S_PAUSE    = 2'd0,
    S_GO_PLAY  = 2'd1,
    S_PLAY     = 2'd2,
    S_GO_PAUSE = 2'd3
  } state_t;

  localparam logic PLAY  = 1'b1;
  localparam logic PAUSE = 1'b0;

  function automatic logic saida_of(input state_t s);
    return (s == S_GO_PLAY || s == S_PLAY) ? PLAY : PAUSE;
  endfunction

endpackage

// File: rtl/play_pause_fsm_btn_debounce.sv
// Button conditioner: 2-flop synchronizer followed by an optional stability counter.
// Counter enabled with `define PLAY_PAUSE_DEBOUNCE_EN; otherwise dout is the synchronizer output.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  if (DEBOUNCE_CYCLES < 1 || (DEBOUNCE_CYCLES >> CNT_W) != 0) begin : g_bad_params
    $error("btn_debounce: DEBOUNCE_CYCLES must be >=1 and fit in CNT_W bits");
  end

  logic sync1;
  logic sync2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
    end
  end

`ifdef PLAY_PAUSE_DEBOUNCE_EN
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // Any return to the accepted level before the count completes restarts it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      dout <= 1'b0;
    end else if (sync2 == dout) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      dout <= sync2;
      cnt  <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  assign dout = sync2;
`endif

endmodule

// File: rtl/play_pause_fsm.sv
// Play/pause toggle: each complete debounced button press flips saida (1 = PLAY).
// Debouncer enabled with `define PLAY_PAUSE_DEBOUNCE_EN.
module play_pause_fsm
  import play_pause_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic saida
);

`ifdef PLAY_PAUSE_DEBOUNCE_EN
  localparam int unsigned SETTLE = DEBOUNCE_CYCLES + 3;
`else
  localparam int unsigned SETTLE = 3;
`endif
  localparam int unsigned SET_W = CNT_W + 2;
  localparam logic [SET_W-1:0] SETTLE_VAL = SET_W'(SETTLE);

  logic             btn_db;
  logic             btn_db_q;
  logic             armed;
  logic             press;
  logic             settled;
  logic [SET_W-1:0] settle_cnt;
  state_t           state;
  state_t           state_next;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_debounce (
    .clk  (clk),
    .reset(reset),
    .din  (btn),
    .dout (btn_db)
  );

  // The reset-cleared input pipeline reads as "released" until it has flushed,
  // so arming waits until btn_db reflects the real button level.
  assign settled = (settle_cnt == SETTLE_VAL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      settle_cnt <= '0;
      armed      <= 1'b0;
      btn_db_q   <= 1'b0;
    end else begin
      if (!settled) settle_cnt <= settle_cnt + 1'b1;
      if (settled && !btn_db) armed <= 1'b1;
      btn_db_q <= btn_db;
    end
  end

  assign press = armed && btn_db && !btn_db_q;

  always_comb begin
    state_next = state;
    unique case (state)
      S_PAUSE:    if (press)   state_next = S_GO_PLAY;
      S_GO_PLAY:  if (!btn_db) state_next = S_PLAY;
      S_PLAY:     if (press)   state_next = S_GO_PAUSE;
      S_GO_PAUSE: if (!btn_db) state_next = S_PAUSE;
      default:                 state_next = S_PAUSE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_PAUSE;
      saida <= PAUSE;
    end else begin
      state <= state_next;
      saida <= saida_of(state_next);
    end
  end

endmodule

// File: tb/tb_play_pause_fsm.sv
// Directed self-checking bench for play_pause_fsm (works with or without PLAY_PAUSE_DEBOUNCE_EN).
module tb_play_pause_fsm;

  localparam int unsigned DEBOUNCE_CYCLES = 16;
`ifdef PLAY_PAUSE_DEBOUNCE_EN
  localparam int unsigned LAT = 2 + DEBOUNCE_CYCLES + 1;
`else
  localparam int unsigned LAT = 3;
`endif

  logic clk;
  logic reset;
  logic btn;
  logic saida;

  int unsigned checks = 0;
  int unsigned errors = 0;

  play_pause_fsm #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (5)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .btn  (btn),
    .saida(saida)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Watch saida for n cycles; return number of changes, first change cycle (0 = none).
  task automatic watch(input int unsigned n, output int unsigned changes,
                       output int unsigned first);
    logic prev;
    prev    = saida;
    changes = 0;
    first   = 0;
    for (int unsigned i = 1; i <= n; i++) begin
      @(posedge clk); #1;
      if (saida !== prev) begin
        changes++;
        if (first == 0) first = i;
        prev = saida;
      end
    end
  endtask

  // 500 ns press then 1000 ns release, checking latency and single toggle.
  task automatic press(input string tag, input logic exp_new);
    int unsigned changes;
    int unsigned first;
    @(posedge clk); #1;
    btn = 1'b1;
    watch(50, changes, first);
    chk({tag, "_press_toggles"}, changes, 1);
    chk({tag, "_latency"}, first, LAT);
    chk({tag, "_held_value"}, {31'd0, saida}, {31'd0, exp_new});
    btn = 1'b0;
    watch(100, changes, first);
    chk({tag, "_release_toggles"}, changes, 0);
    chk({tag, "_final_value"}, {31'd0, saida}, {31'd0, exp_new});
  endtask

  initial begin
    int unsigned changes;
    int unsigned first;

    reset = 1'b1;
    btn   = 1'b0;
    #1;
    chk("reset_active", {31'd0, saida}, 0);
    #9;
    reset = 1'b0;
    watch(40, changes, first);
    chk("post_reset_toggles", changes, 0);
    chk("post_reset_value", {31'd0, saida}, 0);

    press("press1", 1'b1);
    press("press2", 1'b0);
    press("press3", 1'b1);

    // Asynchronous reset mid-cycle must clear saida before the next edge.
    repeat (10) @(posedge clk);
    #1;
    chk("pre_async_reset", {31'd0, saida}, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_clear", {31'd0, saida}, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_hold", {31'd0, saida}, 0);

    // Button held across reset deassertion is not a press.
    btn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    watch(60, changes, first);
    chk("held_through_reset_toggles", changes, 0);
    chk("held_through_reset_value", {31'd0, saida}, 0);
    btn = 1'b0;
    watch(60, changes, first);
    chk("held_release_toggles", changes, 0);
    chk("held_release_value", {31'd0, saida}, 0);
    press("press_after_hold", 1'b1);

`ifdef PLAY_PAUSE_DEBOUNCE_EN
    for (int unsigned r = 0; r < 2; r++) begin
      btn = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      btn = 1'b0;
      repeat (5) @(posedge clk);
      #1;
    end
    watch(40, changes, first);
    chk("glitch_toggles", changes, 0);
    chk("glitch_value", {31'd0, saida}, 1);
    press("press_after_glitch", 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
